pdi_scan_sequencer: RTL and testbench
=====================================

// Module: pdi_scan_sequencer
// PURPOSE
//  Sequences the external serial-to-parallel chain on the PdiDat/PdiClk/PdiLt pins:
//  - generates the latch and shift-clock waveforms on both channels;
//  - shifts in bearing (channel 0) and ship heading (channel 1), MSB first;
//  - publishes confirmed Bear/Ship words with a one-cycle Valid strobe.
//  Sits between the board pins and the external bearing/ship select path, in the Clk40M domain.
// PARAMETERS
//  DIV        2    Clk cycles per half-period of PdiClk and per latch pulse (must be >=1)
//  BEAR_BITS  12   bits shifted on channel 0
//  SHIP_BITS  8    bits shifted on channel 1 (must be <= BEAR_BITS)
//  SCAN_GAP   16   idle Clk cycles between frames (must be >=1)
// PORTS
//  Clk         in   1          system clock (40 MHz)
//  Reset       in   1          synchronous reset, active-high
//  Enable      in   1          continuous scan enable
//  PdiDat      in   2          serial data: [0] bear chain, [1] ship chain
//  PdiClk      out  2          shift clocks to chains
//  PdiLt       out  2          latch pulses to chains (both bits identical)
//  Bear        out  BEAR_BITS  last confirmed bearing word
//  Ship        out  SHIP_BITS  last confirmed ship word
//  Valid       out  1          1-cycle strobe: Bear/Ship updated this cycle
//  Mismatch    out  1          1-cycle strobe: frame differed from previous frame, outputs held
//  FrameCount  out  8          frames completed, wraps 255->0
//  Busy        out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE; all outputs 0; shift regs and previous-frame regs cleared; prev_ok=0.
//  FSM: IDLE -> LATCH -> SHIFT -> UPDATE -> GAP -> (LATCH if Enable, else IDLE).
//  - IDLE: PdiClk=0, PdiLt=0. Enable sampled high -> LATCH on next edge.
//  - LATCH: PdiLt=2'b11 for exactly DIV cycles, then SHIFT.
//  - SHIFT: BEAR_BITS bit-slots, each 2*DIV cycles:
//    - PdiClk low for DIV cycles, then high for DIV cycles.
//    - PdiDat sampled on the last low cycle of each slot (one cycle before the rising PdiClk).
//    - PdiClk[1] toggles only in slots 0..SHIP_BITS-1; it stays 0 afterwards.
//    - Channel-1 samples after SHIP_BITS are ignored.
//  - UPDATE (1 cycle): compare {bear_sh, ship_sh} against the previous frame.
//    - Equal and prev_ok=1: Bear/Ship loaded, Valid=1 this cycle.
//    - Otherwise: Mismatch=1 (not on the first frame after reset), outputs held.
//    - Either way: previous frame <= new frame, prev_ok<=1, FrameCount += 1 mod 256.
//  - GAP: SCAN_GAP cycles with PdiClk=0 and PdiLt=0.
//  Frame latency, LATCH entry to UPDATE cycle: DIV + 2*DIV*BEAR_BITS cycles (DIV=2 -> 50).
//  Enable drop mid-frame: the frame completes through UPDATE and GAP, then IDLE. No truncated frame.
//  Enable held: frames repeat back-to-back with period DIV + 2*DIV*BEAR_BITS + 1 + SCAN_GAP.
//  Reset mid-frame: at the next edge all state returns to reset values. No Valid. prev_ok cleared.
//  Valid and Mismatch are mutually exclusive and only ever asserted in UPDATE.
//  Counters sized by $clog2; slot/phase counters must never overflow for legal parameters.
//  All outputs registered: no combinational path from PdiDat or Enable to outputs.
// TESTING
//  1. DIV=2, chains present 0xA5C/0x3E for two frames:
//     - frame 1: Mismatch=0, Valid=0;
//     - frame 2: Valid=1 for 1 cycle, Bear=0xA5C, Ship=0x3E, FrameCount=2.
//  2. Waveform check per frame:
//     - PdiLt high for exactly 2 cycles;
//     - exactly 12 rising edges on PdiClk[0] and 8 on PdiClk[1];
//     - Valid 50 cycles after LATCH entry.
//  3. Bear changes 0x123 -> 0x124 between frames:
//     - Mismatch pulse, Bear holds 0x123;
//     - next equal frame -> Valid, Bear=0x124.
//  4. Enable deasserted in bit-slot 5: frame finishes (FrameCount+1), GAP, then IDLE with Busy=0.
//  5. Reset asserted mid-SHIFT:
//     - next cycle all outputs 0, PdiClk=PdiLt=0;
//     - after release with Enable high, the first frame yields no Valid.
//  6. 256 frames: FrameCount wraps 255->0 with no effect on Valid or Bear.

Source files
------------

// File: rtl/pdi_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// pdi_scan_sequencer_if
//   Bundles the board-side serial chain pins and the published result bus of
//   the PDI scan sequencer into one interface.
//
//   Signals
//     Enable      continuous scan enable (from control logic)
//     PdiDat[1:0] serial data from chains: [0] bearing, [1] ship heading
//     PdiClk[1:0] shift clocks to the chains
//     PdiLt[1:0]  latch pulses to the chains (both bits identical)
//     Bear        last confirmed bearing word
//     Ship        last confirmed ship heading word
//     Valid       1-cycle strobe, Bear/Ship updated
//     Mismatch    1-cycle strobe, frame differed from previous one
//     FrameCount  frames completed, wraps 255 -> 0
//     Busy        sequencer is not idle
//
//   Modports
//     master  the sequencer itself (drives pins and result bus)
//     slave   the surroundings (chains and consumers)
// ---------------------------------------------------------------------------
interface pdi_scan_sequencer_if #(
  parameter int BEAR_BITS = 12,
  parameter int SHIP_BITS = 8
);

  logic                 Enable;
  logic [1:0]           PdiDat;
  logic [1:0]           PdiClk;
  logic [1:0]           PdiLt;
  logic [BEAR_BITS-1:0] Bear;
  logic [SHIP_BITS-1:0] Ship;
  logic                 Valid;
  logic                 Mismatch;
  logic [7:0]           FrameCount;
  logic                 Busy;

  modport master (
    input  Enable, PdiDat,
    output PdiClk, PdiLt, Bear, Ship, Valid, Mismatch, FrameCount, Busy
  );

  modport slave (
    output Enable, PdiDat,
    input  PdiClk, PdiLt, Bear, Ship, Valid, Mismatch, FrameCount, Busy
  );

endinterface

// File: rtl/pdi_scan_sequencer.sv
// ---------------------------------------------------------------------------
// pdi_scan_sequencer
//   Drives the external serial-to-parallel chains: pulses the latch, clocks
//   out BEAR_BITS bearing bits (channel 0) and SHIP_BITS ship heading bits
//   (channel 1), MSB first, and publishes a word only once two consecutive
//   frames agree. A disagreeing frame raises a Mismatch strobe and leaves the
//   published words untouched.
//
//   Ports
//     Clk    system clock (Clk40M domain)
//     Reset  synchronous reset, active-high
//     bus    pdi_scan_sequencer_if.master: Enable/PdiDat in, pins and result
//            bus out (see interface header)
//
//   Parameters
//     DIV        Clk cycles per PdiClk half-period and per latch pulse (>=1)
//     BEAR_BITS  bits shifted on channel 0
//     SHIP_BITS  bits shifted on channel 1 (<= BEAR_BITS)
//     SCAN_GAP   idle Clk cycles between frames (>=1)
// ---------------------------------------------------------------------------
module pdi_scan_sequencer #(
  parameter int DIV       = 2,
  parameter int BEAR_BITS = 12,
  parameter int SHIP_BITS = 8,
  parameter int SCAN_GAP  = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  pdi_scan_sequencer_if.master   bus
);

  localparam int PH_W    = $clog2(2 * DIV);
  localparam int SLOT_W  = $clog2(BEAR_BITS + 1);
  localparam int GAP_W   = $clog2(SCAN_GAP + 1);
  localparam int FRAME_W = BEAR_BITS + SHIP_BITS;

  localparam logic [PH_W-1:0]   PH_LOW_LAST = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(2 * DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(BEAR_BITS - 1);
  localparam logic [SLOT_W-1:0] SHIP_SLOTS  = SLOT_W'(SHIP_BITS);
  localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(SCAN_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT,
    UPDATE,
    GAP
  } state_e;

  state_e               state_q;
  logic [PH_W-1:0]      phase_q;
  logic [SLOT_W-1:0]    slot_q;
  logic [GAP_W-1:0]     gap_q;
  logic [BEAR_BITS-1:0] bearSh_q;
  logic [SHIP_BITS-1:0] shipSh_q;
  logic [FRAME_W-1:0]   prevFrame_q;
  logic                 prevOk_q;
  logic [1:0]           pdiClk_q;
  logic [1:0]           pdiLt_q;
  logic [BEAR_BITS-1:0] bear_q;
  logic [SHIP_BITS-1:0] ship_q;
  logic                 valid_q;
  logic                 mismatch_q;
  logic [7:0]           frameCount_q;
  logic                 busy_q;

  // The freshly shifted frame is what prevFrame_q takes on at the end of the
  // shift phase, so it doubles as the comparison operand.
  logic [FRAME_W-1:0]   frame_d;
  logic                 frameEq;

  assign frame_d = {bearSh_q, shipSh_q};
  assign frameEq = (frame_d == prevFrame_q);

  // Single sequencer FSM. Every pin and result output is a register that is
  // loaded on the same edge the state/counters move, so the outputs always
  // describe the cycle the FSM is in. The confirm/mismatch decision is made
  // on the edge leaving the last shift cycle; the last data sample was taken
  // DIV cycles earlier, so the shift registers are already complete and the
  // strobes are visible during the single UPDATE cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      slot_q       <= '0;
      gap_q        <= '0;
      bearSh_q     <= '0;
      shipSh_q     <= '0;
      prevFrame_q  <= '0;
      prevOk_q     <= 1'b0;
      pdiClk_q     <= 2'b00;
      pdiLt_q      <= 2'b00;
      bear_q       <= '0;
      ship_q       <= '0;
      valid_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      frameCount_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;

      case (state_q)
        IDLE: begin
          pdiClk_q <= 2'b00;
          pdiLt_q  <= 2'b00;
          if (bus.Enable) begin
            state_q <= LATCH;
            phase_q <= '0;
            pdiLt_q <= 2'b11;
            busy_q  <= 1'b1;
          end
        end

        LATCH: begin
          if (phase_q == PH_LOW_LAST) begin
            state_q <= SHIFT;
            phase_q <= '0;
            slot_q  <= '0;
            pdiLt_q <= 2'b00;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        SHIFT: begin
          // Last low cycle of the slot: sample the chains, then raise the
          // clocks. Channel 1 only participates in its first SHIP_BITS slots.
          if (phase_q == PH_LOW_LAST) begin
            bearSh_q <= (bearSh_q << 1) | BEAR_BITS'(bus.PdiDat[0]);
            if (slot_q < SHIP_SLOTS) begin
              shipSh_q <= (shipSh_q << 1) | SHIP_BITS'(bus.PdiDat[1]);
            end
            pdiClk_q <= {(slot_q < SHIP_SLOTS), 1'b1};
          end

          if (phase_q == PH_LAST) begin
            phase_q  <= '0;
            pdiClk_q <= 2'b00;
            if (slot_q == SLOT_LAST) begin
              state_q <= UPDATE;
              if (frameEq && prevOk_q) begin
                bear_q  <= bearSh_q;
                ship_q  <= shipSh_q;
                valid_q <= 1'b1;
              end else if (prevOk_q) begin
                mismatch_q <= 1'b1;
              end
              prevFrame_q  <= frame_d;
              prevOk_q     <= 1'b1;
              frameCount_q <= frameCount_q + 8'd1;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        UPDATE: begin
          state_q <= GAP;
          gap_q   <= '0;
        end

        GAP: begin
          if (gap_q == GAP_LAST) begin
            if (bus.Enable) begin
              state_q <= LATCH;
              phase_q <= '0;
              pdiLt_q <= 2'b11;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PdiClk     = pdiClk_q;
  assign bus.PdiLt      = pdiLt_q;
  assign bus.Bear       = bear_q;
  assign bus.Ship       = ship_q;
  assign bus.Valid      = valid_q;
  assign bus.Mismatch   = mismatch_q;
  assign bus.FrameCount = frameCount_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_pdi_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pdi_scan_sequencer
//   Drives pdi_scan_sequencer through directed and random frames. Two
//   behavioural shift chains answer the latch/clock pins, and a frame-level
//   reference model predicts Valid/Mismatch/Bear/Ship/FrameCount per frame.
// ---------------------------------------------------------------------------
module tb_pdi_scan_sequencer;

  localparam int DIV       = 2;
  localparam int BEAR_BITS = 12;
  localparam int SHIP_BITS = 8;
  localparam int SCAN_GAP  = 16;
  localparam int LATENCY   = DIV + 2 * DIV * BEAR_BITS;
  localparam int FRAME_W   = BEAR_BITS + SHIP_BITS;

  logic Clk = 1'b0;
  logic Reset;

  int assertCount = 0;
  int failCount   = 0;

  pdi_scan_sequencer_if #(.BEAR_BITS(BEAR_BITS), .SHIP_BITS(SHIP_BITS)) bus ();

  pdi_scan_sequencer #(
    .DIV      (DIV),
    .BEAR_BITS(BEAR_BITS),
    .SHIP_BITS(SHIP_BITS),
    .SCAN_GAP (SCAN_GAP)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  // External chain model: parallel load on the rising latch, shift left on
  // each rising PdiClk, serial output is the current MSB.
  logic [BEAR_BITS-1:0] bearWord = '0;
  logic [SHIP_BITS-1:0] shipWord = '0;
  logic [BEAR_BITS-1:0] bearChain = '0;
  logic [SHIP_BITS-1:0] shipChain = '0;
  logic                 ltPrev = 1'b0;
  logic [1:0]           clkPrev = 2'b00;

  always @(negedge Clk) begin
    if (bus.PdiLt[0] && !ltPrev) begin
      bearChain <= bearWord;
      shipChain <= shipWord;
    end else begin
      if (bus.PdiClk[0] && !clkPrev[0]) bearChain <= bearChain << 1;
      if (bus.PdiClk[1] && !clkPrev[1]) shipChain <= shipChain << 1;
    end
    ltPrev  <= bus.PdiLt[0];
    clkPrev <= bus.PdiClk;
  end

  assign bus.PdiDat = {shipChain[SHIP_BITS-1], bearChain[BEAR_BITS-1]};

  // Frame-level reference model state
  logic [FRAME_W-1:0]   mPrev   = '0;
  bit                   mPrevOk = 1'b0;
  logic [BEAR_BITS-1:0] mBear   = '0;
  logic [SHIP_BITS-1:0] mShip   = '0;
  logic [7:0]           mCount  = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mPrev   = '0;
    mPrevOk = 1'b0;
    mBear   = '0;
    mShip   = '0;
    mCount  = '0;
  endtask

  // Presents one word pair to the chains, follows one frame from latch entry
  // to its UPDATE cycle, and checks waveform and results. dropAt >= 0 drops
  // Enable that many cycles after latch entry. Returns one cycle after UPDATE.
  task automatic applyStimulus(input logic [BEAR_BITS-1:0] bw, input logic [SHIP_BITS-1:0] sw,
                               input string tag, input int dropAt);
    int         waitCycles;
    int         ltCycles;
    int         rise0;
    int         rise1;
    logic [1:0] prevClk;
    bit         early;
    bit         eq;
    bit         expValid;
    bit         expMismatch;
    bearWord = bw;
    shipWord = sw;
    waitCycles = 0;
    while (bus.PdiLt !== 2'b11 && waitCycles < 300) begin
      @(negedge Clk);
      waitCycles++;
    end
    checkOutput({tag, "_latch_seen"}, 32'(bus.PdiLt === 2'b11), 32'd1);
    if (bus.PdiLt !== 2'b11) return;

    ltCycles = 0;
    rise0    = 0;
    rise1    = 0;
    prevClk  = 2'b00;
    early    = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      if (k == dropAt) bus.Enable = 1'b0;
      if (bus.PdiLt === 2'b11) ltCycles++;
      if (bus.PdiClk[0] === 1'b1 && prevClk[0] === 1'b0) rise0++;
      if (bus.PdiClk[1] === 1'b1 && prevClk[1] === 1'b0) rise1++;
      prevClk = bus.PdiClk;
      if (bus.Valid !== 1'b0 || bus.Mismatch !== 1'b0) early = 1'b1;
      @(negedge Clk);
    end

    eq          = mPrevOk && ({bw, sw} == mPrev);
    expValid    = eq;
    expMismatch = mPrevOk && !eq;
    if (eq) begin
      mBear = bw;
      mShip = sw;
    end
    mPrev   = {bw, sw};
    mPrevOk = 1'b1;
    mCount  = mCount + 8'd1;

    checkOutput({tag, "_latch_cycles"}, 32'(ltCycles), 32'(DIV));
    checkOutput({tag, "_rise_ch0"}, 32'(rise0), 32'(BEAR_BITS));
    checkOutput({tag, "_rise_ch1"}, 32'(rise1), 32'(SHIP_BITS));
    checkOutput({tag, "_early_strobe"}, 32'(early), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus.Valid), 32'(expValid));
    checkOutput({tag, "_mismatch"}, 32'(bus.Mismatch), 32'(expMismatch));
    checkOutput({tag, "_bear"}, 32'(bus.Bear), 32'(mBear));
    checkOutput({tag, "_ship"}, 32'(bus.Ship), 32'(mShip));
    checkOutput({tag, "_count"}, 32'(bus.FrameCount), 32'(mCount));
    checkOutput({tag, "_busy"}, 32'(bus.Busy), 32'd1);
    @(negedge Clk);
    checkOutput({tag, "_strobe_width"}, 32'(bus.Valid | bus.Mismatch), 32'd0);
  endtask

  initial begin
    logic [BEAR_BITS-1:0] rb;
    logic [SHIP_BITS-1:0] rs;
    int                   waitCycles;
    bit                   ltSeen;

    // Reset state
    Reset      = 1'b1;
    bus.Enable = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("rst_bear", 32'(bus.Bear), 32'd0);
    checkOutput("rst_ship", 32'(bus.Ship), 32'd0);
    checkOutput("rst_valid", 32'(bus.Valid), 32'd0);
    checkOutput("rst_mismatch", 32'(bus.Mismatch), 32'd0);
    checkOutput("rst_count", 32'(bus.FrameCount), 32'd0);
    checkOutput("rst_busy", 32'(bus.Busy), 32'd0);
    checkOutput("rst_pins", 32'({bus.PdiClk, bus.PdiLt}), 32'd0);

    // Two identical frames: first unconfirmed, second confirmed
    $display("[TB] two identical frames");
    bus.Enable = 1'b1;
    applyStimulus(12'hA5C, 8'h3E, "same1", -1);
    applyStimulus(12'hA5C, 8'h3E, "same2", -1);
    checkOutput("same2_fixed_bear", 32'(bus.Bear), 32'hA5C);
    checkOutput("same2_fixed_count", 32'(bus.FrameCount), 32'd2);

    // Bearing change between frames
    $display("[TB] bearing change");
    applyStimulus(12'h123, 8'h5A, "chg_a", -1);
    applyStimulus(12'h123, 8'h5A, "chg_b", -1);
    applyStimulus(12'h124, 8'h5A, "chg_c", -1);
    checkOutput("chg_c_hold", 32'(bus.Bear), 32'h123);
    applyStimulus(12'h124, 8'h5A, "chg_d", -1);
    checkOutput("chg_d_new", 32'(bus.Bear), 32'h124);

    // Random frames, repeating the previous word about half the time
    $display("[TB] random frames");
    rb = 12'(($urandom));
    rs = 8'(($urandom));
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        rb = 12'(($urandom));
        rs = 8'(($urandom));
      end
      applyStimulus(rb, rs, "rnd", -1);
    end

    // Enable dropped in bit-slot 5: frame completes, gap, then idle
    $display("[TB] enable drop");
    applyStimulus(12'h3C3, 8'h81, "drop", DIV + 5 * 2 * DIV + 1);
    repeat (SCAN_GAP - 1) @(negedge Clk);
    checkOutput("drop_gap_busy", 32'(bus.Busy), 32'd1);
    @(negedge Clk);
    checkOutput("drop_idle_busy", 32'(bus.Busy), 32'd0);
    ltSeen = 1'b0;
    for (int i = 0; i < 3 * SCAN_GAP; i++) begin
      if (bus.PdiLt !== 2'b00 || bus.PdiClk !== 2'b00) ltSeen = 1'b1;
      @(negedge Clk);
    end
    checkOutput("drop_stays_idle", 32'(ltSeen), 32'd0);
    checkOutput("drop_count", 32'(bus.FrameCount), 32'(mCount));

    // Reset in the middle of SHIFT
    $display("[TB] reset mid-shift");
    bearWord   = 12'h6B1;
    shipWord   = 8'hC4;
    bus.Enable = 1'b1;
    waitCycles = 0;
    while (bus.PdiLt !== 2'b11 && waitCycles < 300) begin
      @(negedge Clk);
      waitCycles++;
    end
    checkOutput("mid_latch_seen", 32'(bus.PdiLt === 2'b11), 32'd1);
    repeat (DIV + 2 * DIV * 4 + 1) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("mid_rst_bear", 32'(bus.Bear), 32'd0);
    checkOutput("mid_rst_ship", 32'(bus.Ship), 32'd0);
    checkOutput("mid_rst_strobes", 32'({bus.Valid, bus.Mismatch}), 32'd0);
    checkOutput("mid_rst_count", 32'(bus.FrameCount), 32'd0);
    checkOutput("mid_rst_busy", 32'(bus.Busy), 32'd0);
    checkOutput("mid_rst_pins", 32'({bus.PdiClk, bus.PdiLt}), 32'd0);
    Reset = 1'b0;
    resetModel();
    applyStimulus(12'h6B1, 8'hC4, "post_rst1", -1);
    applyStimulus(12'h6B1, 8'hC4, "post_rst2", -1);

    // 256 frames: FrameCount wraps through 255 -> 0
    $display("[TB] frame counter wrap");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(12'h6B1, 8'hC4, "wrap", -1);
    end
    checkOutput("wrap_final_count", 32'(bus.FrameCount), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
